uart_bus_ctrl: RTL

Wishbone-slave UART controller that sits between the OpenMIPS data bus and the 8N2 serial transmitter / 8N1 serial receiver drivers. It provides a 16-entry TX FIFO that feeds the transmitter through its start/busy handshake, and a 16-entry RX FIFO that captures each receiver data-ready pulse. It exposes DATA, STATUS and CTRL registers and a level interrupt.

---
 rtl/uart_bus_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/uart_bus_ctrl.sv
// uart_bus_ctrl: Wishbone UART controller with TX/RX byte FIFOs, status/control registers and level irq
module uart_bus_ctrl #(
  parameter int FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic        irq
);
  localparam int DEPTH = 1 << FIFO_AW;
  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} txState_t;
  txState_t txState;
  logic [7:0] txMem [DEPTH];
  logic [7:0] rxMem [DEPTH];
  logic [FIFO_AW-1:0] txWr, txRd, rxWr, rxRd;
  logic [FIFO_AW:0] txCnt, rxCnt;
  logic rxOvr, txOvf;
  logic [1:0] ctrl;
  logic req, busWr, busRd, txFull, txEmpty, rxFull, rxEmpty;
  logic txPush, txPop, txAccept, rxPop, rxAccept, clrRxOvr, clrTxOvf, unusedBits;
  logic [31:0] status, rdData;
  always_comb begin
    req = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    busWr = req & wb_we_i;
    busRd = req & ~wb_we_i;
    txFull = txCnt == (FIFO_AW+1)'(DEPTH);
    txEmpty = txCnt == '0;
    rxFull = rxCnt == (FIFO_AW+1)'(DEPTH);
    rxEmpty = rxCnt == '0;
    txPush = busWr & (wb_adr_i == 2'd0);
    txPop = (txState == IDLE) & ~txEmpty & ~tx_busy;
    txAccept = txPush & (~txFull | txPop);
    rxPop = busRd & (wb_adr_i == 2'd0) & ~rxEmpty;
    rxAccept = rx_ready & (~rxFull | rxPop);
    clrRxOvr = busWr & (wb_adr_i == 2'd1) & wb_dat_i[4];
    clrTxOvf = busWr & (wb_adr_i == 2'd1) & wb_dat_i[5];
    unusedBits = ^wb_dat_i[31:8];
    status = '0;
    status[0] = txFull;
    status[1] = txEmpty;
    status[2] = ~rxEmpty;
    status[3] = rxFull;
    status[4] = rxOvr;
    status[5] = txOvf;
    status[6] = (txState != IDLE) | tx_busy;
    status[8 +: FIFO_AW+1] = rxCnt;
    rdData = wb_adr_i == 2'd0 ? (rxEmpty ? 32'd0 : {24'd0, rxMem[rxRd]}) :
             wb_adr_i == 2'd1 ? status :
             wb_adr_i == 2'd2 ? {30'd0, ctrl} : 32'd0;
  end
  // Storage is not reset: emptiness comes from the pointers and counts alone.
  always_ff @(posedge clk) begin
    if (txAccept) txMem[txWr] <= wb_dat_i[7:0];
    if (rxAccept) rxMem[rxWr] <= rx_data;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      tx_start <= 1'b0;
      tx_data <= '0;
      irq <= 1'b0;
      ctrl <= '0;
      txWr <= '0;
      txRd <= '0;
      txCnt <= '0;
      rxWr <= '0;
      rxRd <= '0;
      rxCnt <= '0;
      rxOvr <= 1'b0;
      txOvf <= 1'b0;
      txState <= IDLE;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= busRd ? rdData : '0;
      if (busWr && wb_adr_i == 2'd2) ctrl <= wb_dat_i[1:0];
      txWr <= txWr + FIFO_AW'(txAccept);
      txRd <= txRd + FIFO_AW'(txPop);
      txCnt <= txCnt + (FIFO_AW+1)'(txAccept) - (FIFO_AW+1)'(txPop);
      rxWr <= rxWr + FIFO_AW'(rxAccept);
      rxRd <= rxRd + FIFO_AW'(rxPop);
      rxCnt <= rxCnt + (FIFO_AW+1)'(rxAccept) - (FIFO_AW+1)'(rxPop);
      txOvf <= (txOvf & ~clrTxOvf) | (txPush & ~txAccept);
      rxOvr <= (rxOvr & ~clrRxOvr) | (rx_ready & ~rxAccept);
      irq <= (ctrl[0] & ~rxEmpty) | (ctrl[1] & txEmpty & (txState == IDLE) & ~tx_busy) | rxOvr | txOvf;
      tx_start <= txPop;
      if (txPop) tx_data <= txMem[txRd];
      txState <= txState == IDLE ? (txPop ? WAIT_BUSY : IDLE) :
                 txState == WAIT_BUSY ? (tx_busy ? WAIT_DONE : WAIT_BUSY) :
                 (tx_busy ? WAIT_DONE : IDLE);
    end
  end
endmodule
